// File: rtl/fs_clk_gen_pkg.sv
// fs_clk_gen_pkg: shared state encoding and default widths for the multi-channel sampling-clock generator.
package fs_clk_gen_pkg;
    localparam int CNT_W = 24;
    localparam int BURST_W = 16;
    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;
endpackage

// File: rtl/fs_clk_chan.sv
// fs_clk_chan: one divided sampling clock with a phase delay from the go pulse to its first high.
module fs_clk_chan #(
    parameter int CNT_W = fs_clk_gen_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             stop,
    input  logic [CNT_W-1:0] max,
    input  logic [CNT_W-1:0] ofs,
    output logic             fs_clk,
    output logic             fs_rise,
    output logic             fall
);
    logic             act;
    logic             wt;
    logic [CNT_W-1:0] ph;
    logic [CNT_W-1:0] hp;

    // fall flags the cycle whose edge takes the clock low, so a burst can end exactly there
    assign fall = act && fs_clk && hp == max;

    always_ff @(posedge clk) begin
        if (reset || stop) begin
            act     <= 1'b0;
            wt      <= 1'b0;
            ph      <= '0;
            hp      <= '0;
            fs_clk  <= 1'b0;
            fs_rise <= 1'b0;
        end else if (go) begin
            act     <= ofs == '0;
            wt      <= ofs != '0;
            ph      <= ofs;
            hp      <= '0;
            fs_clk  <= ofs == '0;
            fs_rise <= ofs == '0;
        end else if (wt) begin
            wt      <= ph != CNT_W'(1);
            act     <= ph == CNT_W'(1);
            fs_clk  <= ph == CNT_W'(1);
            fs_rise <= ph == CNT_W'(1);
            ph      <= ph - CNT_W'(1);
        end else if (act) begin
            hp      <= (hp == max) ? '0 : hp + CNT_W'(1);
            fs_clk  <= fs_clk ^ (hp == max);
            fs_rise <= !fs_clk && hp == max;
        end else begin
            fs_rise <= 1'b0;
        end
    end
endmodule

// File: rtl/fs_clk_gen_multi.sv
// fs_clk_gen_multi: arm/trigger FSM driving NCH phase-offset sampling clocks.
// Define FS_CLK_GEN_BURST_EN to stop after burst_len ch0 rising edges (DONE state).
module fs_clk_gen_multi import fs_clk_gen_pkg::*; #(
    parameter int NCH     = 4,
    parameter int CNT_W   = fs_clk_gen_pkg::CNT_W,
    parameter int BURST_W = fs_clk_gen_pkg::BURST_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               trigger,
    input  logic [NCH*CNT_W-1:0] fs_cnt_max,
    input  logic [NCH*CNT_W-1:0] phase_ofs,
    input  logic [BURST_W-1:0] burst_len,
    output logic [NCH-1:0]     fs_clk,
    output logic [NCH-1:0]     fs_rise,
    output logic               running,
    output logic               done
);
    state_t               state;
    logic [NCH*CNT_W-1:0] max_q;
    logic [NCH-1:0]       ch_fall;
    logic                 go;
    logic                 stop;
    logic                 hit;
    logic                 unused_fall;

    assign go          = state == ARMED && start && trigger;
    assign stop        = state == RUN && (!start || hit);
    assign unused_fall = ^ch_fall;

`ifdef FS_CLK_GEN_BURST_EN
    logic [BURST_W-1:0] blen;
    logic [BURST_W-1:0] bcnt;

    // a rise landing in the same cycle as the fall (max=0) must already count
    assign hit = blen != '0 && ch_fall[0] && bcnt + BURST_W'(fs_rise[0]) == blen;

    always_ff @(posedge clk) begin
        if (reset) begin
            blen <= '0;
            bcnt <= '0;
        end else if (go) begin
            blen <= burst_len;
            bcnt <= '0;
        end else if (state == RUN) begin
            bcnt <= bcnt + BURST_W'(fs_rise[0]);
        end
    end
`else
    logic unused_burst;

    assign unused_burst = ^burst_len;
    assign hit          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
            max_q   <= '0;
        end else begin
            case (state)
                IDLE: if (start) state <= ARMED;
                ARMED: begin
                    if (!start) begin
                        state <= IDLE;
                    end else if (trigger) begin
                        state   <= RUN;
                        running <= 1'b1;
                        max_q   <= fs_cnt_max;
                    end
                end
                RUN: begin
                    if (!start) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end else if (hit) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        fs_clk_chan #(.CNT_W(CNT_W)) u_chan (
            .clk     (clk),
            .reset   (reset),
            .go      (go),
            .stop    (stop),
            .max     (max_q[i*CNT_W +: CNT_W]),
            .ofs     (phase_ofs[i*CNT_W +: CNT_W]),
            .fs_clk  (fs_clk[i]),
            .fs_rise (fs_rise[i]),
            .fall    (ch_fall[i])
        );
    end
endmodule
